md5_msg_sched: RTL and testbench

Message-word scheduler for the MD5 compute core. It accepts one 512-bit block as 16 words over a valid/ready input stream. It then replays those words as a 64-entry stream, one per round step i = 0..63. Each output carries word M[g(i)] under the standard MD5 index permutation, together with i and g, for the round-function datapath.

---
 rtl/md5_pkg.sv | 17 +
 rtl/md5_gindex.sv | 19 +
 rtl/md5_msg_sched.sv | 96 +++++++++
 tb/tb_md5_msg_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 message scheduler: FSM states, block geometry
// and the per-round coefficients of the message index permutation.
package md5_pkg;

   typedef enum logic {
      LOAD  = 1'b0,
      SERVE = 1'b1
   } state_e;

   localparam int WORDS_PER_BLOCK = 16;
   localparam int STEPS           = 64;

   // g(i) = (G_MULT[r] * i + G_ADD[r]) mod 16, r = i[5:4]; nibble r holds round r.
   localparam logic [15:0] G_MULT = {4'd7, 4'd3, 4'd5, 4'd1};
   localparam logic [15:0] G_ADD  = {4'd0, 4'd5, 4'd1, 4'd0};

endpackage

// File: rtl/md5_gindex.sv
// Combinational MD5 message index permutation: round step i -> word index g.
module md5_gindex
   import md5_pkg::*;
(
   input  logic [5:0] i,
   output logic [3:0] g
);

   logic [3:0] mult;
   logic [3:0] add;

   // Only i mod 16 matters because the whole product is taken mod 16.
   always_comb begin
      mult = G_MULT[{i[5:4], 2'b00} +: 4];
      add  = G_ADD[{i[5:4], 2'b00} +: 4];
      g    = mult * i[3:0] + add;
   end

endmodule

// File: rtl/md5_msg_sched.sv
// MD5 message scheduler: captures a 16-word block, then replays it as 64
// round steps carrying M[g(i)], i and g.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; valid/ready depend only on registered state, and outputs hold until
// their transfer.
module md5_msg_sched
   import md5_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [5:0]        out_index,
   output logic [3:0]        out_g,
   output logic              out_last,
   output state_e            dbg_state
);

   localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);
   localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mem_q [WORDS_PER_BLOCK];
   logic [DATA_W-1:0] mem_d [WORDS_PER_BLOCK];
   logic [3:0]        wcnt_q, wcnt_d;
   logic [5:0]        step_q, step_d;
   logic              in_hs;
   logic              out_hs;

   md5_gindex u_gindex (
      .i (step_q),
      .g (out_g)
   );

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      step_d    = step_q;
      mem_d     = mem_q;
      in_ready  = (state_q == LOAD);
      out_valid = (state_q == SERVE);
      in_hs     = in_valid & in_ready;
      out_hs    = out_valid & out_ready;
      case (state_q)
         LOAD: begin
            if (in_hs) begin
               mem_d[wcnt_q] = in_data;
               wcnt_d        = wcnt_q + 4'd1;
               if (wcnt_q == LAST_WORD) begin
                  wcnt_d  = 4'd0;
                  step_d  = 6'd0;
                  state_d = SERVE;
               end
            end
         end
         SERVE: begin
            if (out_hs) begin
               step_d = step_q + 6'd1;
               if (step_q == LAST_STEP) begin
                  step_d  = 6'd0;
                  state_d = LOAD;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Reset discards any partial block, including the stored words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LOAD;
         wcnt_q  <= 4'd0;
         step_q  <= 6'd0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         step_q  <= step_d;
         mem_q   <= mem_d;
      end
   end

   assign out_index = step_q;
   assign out_data  = mem_q[out_g];
   assign out_last  = (step_q == LAST_STEP) && (state_q == SERVE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_md5_msg_sched.sv
// Self-checking bench for md5_msg_sched: block-level reference model feeding an
// expected-output queue, with random valid/ready gaps and mid-block resets.
module tb_md5_msg_sched;
   import md5_pkg::*;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [5:0]        out_index;
   logic [3:0]        out_g;
   logic              out_last;
   state_e            dbg_state;

   md5_msg_sched #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_g     (out_g),
      .out_last  (out_last),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard / model state ----------------
   int                checks   = 0;
   int                failures = 0;
   logic [42:0]       exp_q[$];   // {index, g, last, data}
   logic [DATA_W-1:0] feed_q[$];
   logic [DATA_W-1:0] mmem [16];
   int                mwcnt;
   bit                mserve;
   bit                gap_armed;
   int                gap_cnt;
   int                last_gap;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_g(input int i);
      case (i / 16)
         0:       return 4'(i);
         1:       return 4'(5 * i + 1);
         2:       return 4'(3 * i + 5);
         default: return 4'(7 * i);
      endcase
   endfunction

   function automatic logic [42:0] pack_out(input int i, input logic [DATA_W-1:0] d);
      logic last;
      last = (i == 63);
      return {6'(i), ref_g(i), last, d};
   endfunction

   task automatic push_block();
      for (int i = 0; i < 64; i++) exp_q.push_back(pack_out(i, mmem[ref_g(i)]));
   endtask

   task automatic clear_model();
      exp_q.delete();
      feed_q.delete();
      for (int n = 0; n < 16; n++) mmem[n] = '0;
      mwcnt     = 0;
      mserve    = 0;
      gap_armed = 0;
      gap_cnt   = 0;
      last_gap  = -1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_index", out_index, 0);
      check("rst_out_g", out_g, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_state", dbg_state, LOAD);
      @(negedge clk);
      reset = 1'b0;
      clear_model();
   endtask

   task automatic feed_block(input logic [DATA_W-1:0] base, input int count);
      for (int n = 0; n < count; n++) feed_q.push_back(base + DATA_W'(n));
   endtask

   task automatic feed_random(input int count);
      for (int n = 0; n < count; n++) feed_q.push_back($urandom);
   endtask

   // Runs traffic until the feed is drained and at most stop_left expected
   // steps remain (and, when stop_left is 0, the model is back in LOAD).
   task automatic run(input int in_pct, input int out_pct, input int stop_left, input int max_cycles);
      bit          done;
      bit          ihs;
      bit          ohs;
      int          sg;
      logic [42:0] got;
      done = 0;
      for (int c = 0; c < max_cycles && !done; c++) begin
         @(negedge clk);
         if (mserve) begin
            in_valid = ($urandom_range(99) < in_pct);
            in_data  = $urandom;
         end else if (feed_q.size() > 0) begin
            in_valid = ($urandom_range(99) < in_pct);
            in_data  = in_valid ? feed_q[0] : $urandom;
         end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end
         out_ready = ($urandom_range(99) < out_pct);
         #1;
         check("in_ready", in_ready, !mserve);
         check("out_valid", out_valid, mserve);
         if (out_valid) begin
            got = {out_index, out_g, out_last, out_data};
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else check("out_step", got, exp_q[0]);
            case (out_index)
               6'd16:   sg = 1;
               6'd17:   sg = 6;
               6'd32:   sg = 5;
               6'd33:   sg = 8;
               6'd48:   sg = 0;
               6'd49:   sg = 7;
               6'd63:   sg = 9;
               default: sg = -1;
            endcase
            if (sg >= 0) check($sformatf("spot_g_i%0d", out_index), out_g, sg);
            if (gap_armed) begin
               last_gap  = gap_cnt;
               gap_armed = 0;
            end
         end else if (gap_armed) begin
            gap_cnt++;
         end
         ihs = in_valid && !mserve;
         ohs = out_ready && mserve;
         if (ohs && exp_q.size() > 0) begin
            if (exp_q[0][32]) begin
               mserve    = 0;
               gap_armed = 1;
               gap_cnt   = 0;
            end
            void'(exp_q.pop_front());
         end
         if (ihs) begin
            mmem[mwcnt] = feed_q.pop_front();
            if (mwcnt == 15) begin
               mwcnt  = 0;
               mserve = 1;
               push_block();
            end else begin
               mwcnt++;
            end
         end
         if (feed_q.size() == 0 && exp_q.size() <= stop_left && (stop_left > 0 || !mserve))
            done = 1;
      end
      if (!done) check("timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("post_in_ready", in_ready, !mserve);
      check("post_out_valid", out_valid, mserve);
   endtask

   // ---------------- test sequence / final report ----------------
   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clear_model();
      do_reset();

      // Full-rate block: latency, permutation, out_last and turnaround.
      feed_block(32'h100, 16);
      run(100, 100, 0, 200);

      // Random gaps on both sides over two blocks.
      feed_random(32);
      run(60, 50, 0, 2000);

      // Producer keeps offering during a slow serve.
      feed_random(16);
      run(100, 40, 0, 1000);

      // Reset after 7 loaded words, then a fresh block.
      feed_block(32'h700, 7);
      run(100, 100, 0, 100);
      do_reset();
      feed_block(32'h300, 16);
      run(100, 100, 0, 200);

      // Reset at step 40, then a fresh block.
      feed_random(16);
      run(80, 100, 24, 400);
      do_reset();
      feed_block(32'h400, 16);
      run(100, 100, 0, 200);

      // Back-to-back blocks at full rate with a 16-cycle gap between serves.
      feed_block(32'h100, 16);
      feed_block(32'h200, 16);
      run(100, 100, 0, 400);
      check("block_gap", last_gap, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
